// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over a UART line (8N1, LSB first) and writes it
//   word by word into the processor's instruction/data memory. The stream is
//   a 16-bit little-endian word count N followed by N little-endian 32-bit
//   words. r_done is meant to hold the processor in reset until the image is
//   fully loaded.
//
//   Optional feature (macro LOADER_CHECKSUM_EN): one extra byte after the
//   data, the XOR of all header and data bytes. It must match before r_done
//   rises; a mismatch sets r_err.
//
// Ports
//   w_clk    in   single clock, all state on posedge
//   w_rst    in   asynchronous active-high reset
//   w_rxd    in   UART RX line, idle high, asynchronous to w_clk
//   r_we     out  one-cycle memory write strobe per word
//   r_addr   out  word address of the current write
//   r_wdata  out  word to write, valid while r_we=1
//   r_done   out  image complete, sticky until w_rst
//   r_err    out  load failed (framing, oversize or checksum), sticky until w_rst
//
// Handshake: there is no back-pressure. Every r_we pulse is a complete write
// that the memory must accept in that cycle; r_addr/r_wdata are stable while
// r_we is high.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 12
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_rxd,
   output logic              r_we,
   output logic [ADDR_W-1:0] r_addr,
   output logic [31:0]       r_wdata,
   output logic              r_done,
   output logic              r_err
);

   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]     DEPTH     = 17'(2 ** ADDR_W);

   // ---------------------------------------------------------------- RX
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state;
   logic          rxd_meta, rxd_sync, rxd_prev;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift;
   logic          byte_stb;
   logic          frame_err;

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         rxd_meta  <= 1'b1;
         rxd_sync  <= 1'b1;
         rxd_prev  <= 1'b1;
         rx_state  <= RX_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rxd_meta  <= w_rxd;
         rxd_sync  <= rxd_meta;
         rxd_prev  <= rxd_sync;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rxd_prev && !rxd_sync) begin
                  rx_state <= RX_START;
                  baud_cnt <= '0;
               end
            end
            RX_START: begin
               // Mid-start re-check: a line already back high was a glitch.
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  rx_shift <= {rxd_sync, rx_shift[7:1]};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) rx_state <= RX_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               // Return to idle right at the stop sample so a start edge
               // in the stop-bit tail is caught.
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt  <= '0;
                  byte_stb  <= rxd_sync;
                  frame_err <= !rxd_sync;
                  rx_state  <= RX_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- loader
   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   logic [15:0] n_words;
   logic [1:0]  byte_idx;
   logic [23:0] word_acc;     // first three bytes of the word, byte 0 lowest
   logic [16:0] next_count;   // words written once the current pulse retires
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign next_count = 17'(r_addr) + 17'd1;

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state    <= S_HDR0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         n_words  <= '0;
         byte_idx <= '0;
         word_acc <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         r_we <= 1'b0;

         // Retire the write pulse: either the image is complete or the
         // address moves on. The last address is never incremented, so
         // r_addr cannot wrap even when N equals the memory depth.
         if (r_we) begin
            if (next_count == {1'b0, n_words}) begin
`ifdef LOADER_CHECKSUM_EN
               state  <= S_CSUM;
`else
               state  <= S_DONE;
               r_done <= 1'b1;
`endif
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end

         if (frame_err && state != S_DONE && state != S_ERR) begin
            r_err <= 1'b1;
            state <= S_ERR;
         end else if (byte_stb) begin
            case (state)
               S_HDR0: begin
                  n_words[7:0] <= rx_shift;
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_shift;
`endif
                  state <= S_HDR1;
               end
               S_HDR1: begin
                  n_words[15:8] <= rx_shift;
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_shift;
`endif
                  if ({rx_shift, n_words[7:0]} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state  <= S_CSUM;
`else
                     state  <= S_DONE;
                     r_done <= 1'b1;
`endif
                  end else if ({1'b0, rx_shift, n_words[7:0]} > DEPTH) begin
                     r_err <= 1'b1;
                     state <= S_ERR;
                  end else begin
                     byte_idx <= '0;
                     state    <= S_DATA;
                  end
               end
               S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_shift;
`endif
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     r_we    <= 1'b1;
                     r_wdata <= {rx_shift, word_acc};
                  end else begin
                     word_acc <= {rx_shift, word_acc[23:8]};
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (rx_shift == csum) begin
                     r_done <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     r_err <= 1'b1;
                     state <= S_ERR;
                  end
               end
`endif
               default: ;  // S_DONE and S_ERR ignore further bytes
            endcase
         end
      end
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream stage of the pipelined processor: receives a program image over a UART serial line and writes it word by word into the 4K-word instruction/data memory.
- Its write port drives the memory's address, write-enable and data-in.
- r_done gates the processor reset at top level: proc reset = w_rst | ~r_done. The processor therefore starts at PC 0 only after the image is fully loaded.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 12, memory word-address width; depth = 2**ADDR_W words.

Ports:
- w_clk  in  1  single clock; all state on posedge.
- w_rst  in  1  reset, asynchronous, active-high; every register is cleared immediately on assertion.
- w_rxd  in  1  UART RX line; idle high; 8N1, LSB first; asynchronous to w_clk.
- r_we  out  1  memory write strobe, one-cycle pulse per word.
- r_addr  out  ADDR_W  word address of the current write.
- r_wdata  out  32  word to write; valid while r_we=1.
- r_done  out  1  image complete; sticky until w_rst.
- r_err  out  1  load failed; sticky until w_rst.

Behaviour:
- Reset values:
  - r_we=0, r_addr=0, r_wdata=0, r_done=0, r_err=0.
  - Synchronizer flops = 1; FSM in S_HDR0; bit/baud/byte counters = 0.
- RX front end:
  - 2-FF synchronizer on w_rxd.
  - Start bit is detected on a high-to-low transition of the synchronized line.
  - The line is re-sampled at CLKS_PER_BIT/2 cycles (integer division). If it is high again, the event is a glitch: ignore it and return to idle.
  - 8 data bits are sampled every CLKS_PER_BIT cycles after that, LSB first, followed by the stop bit.
  - Stop bit = 1: assert the internal byte strobe for one cycle, on the cycle after the stop sample.
  - Stop bit = 0: framing error. r_err<=1, FSM -> S_ERR, byte discarded.
  - The receiver re-arms for the next start edge immediately after the stop sample.
- Stream format:
  - 2-byte word count N, little-endian.
  - Then N words of 4 bytes each, little-endian: first byte goes to bits [7:0].
- FSM, advancing on each byte strobe:
  - S_HDR0: latch N[7:0] -> S_HDR1.
  - S_HDR1: latch N[15:8].
    - If N == 0: -> S_DONE.
    - If N > 2**ADDR_W: r_err<=1 -> S_ERR.
    - Otherwise -> S_DATA.
  - S_DATA: shift the byte into the word assembler, counting bytes 0..3.
    - On byte 3, on the cycle after its strobe: r_wdata = assembled word, r_we = 1 for exactly one cycle, r_addr = current word index.
    - r_addr increments the cycle after the pulse; it never wraps, because N <= depth.
    - After the Nth write -> S_DONE (or S_CSUM if the optional feature is enabled).
  - S_DONE: r_done=1. Further serial bytes are received but ignored; no writes occur.
  - S_ERR: r_err=1, r_done stays 0, no further writes. Only w_rst exits this state.
- Latency: the r_we pulse occurs 2 cycles after the mid-stop-bit sample of the word's 4th byte.
- r_done rises:
  - 1 cycle after the last r_we pulse, when N > 0;
  - 1 cycle after the S_HDR1 byte strobe, when N == 0.
- Reset mid-transfer: the partial word is lost and no write is emitted. The next stream restarts at the header and writes from address 0.
- A start edge that arrives during the stop-bit tail is handled normally; back-to-back bytes with no idle gap must be accepted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the last data byte: the XOR of all header and data bytes.
  - FSM goes S_DATA -> S_CSUM -> S_DONE on match.
  - On mismatch: r_err<=1 -> S_ERR.
  - r_done rises 1 cycle after the checksum byte strobe.
  - For N == 0, S_HDR1 goes to S_CSUM instead of S_DONE.
- Undefined: no checksum byte, no S_CSUM state, no XOR register.

Test Plan (CLKS_PER_BIT=4, ADDR_W=12):
- Stream 02 00 | 20 00 01 20 | 01 00 0A 20 -> r_we pulses: addr 0 data 0x20010020, then addr 1 data 0x200A0001; r_done=1 one cycle after the second pulse; r_err=0.
- Stream 00 00 -> no r_we; r_done=1 one cycle after the second byte strobe.
- Stream 01 00 11 22, then a byte with stop bit = 0 -> r_err=1, no r_we, r_done stays 0; later valid bytes are ignored.
- Stream 01 10 (N=0x1001 > 4096) -> r_err=1 after the header, no writes.
- Assert w_rst after 2 data bytes of a word, then send the full stream from scenario 1 -> writes land at addr 0 and 1 with the correct data; no stale partial word is written.
- 1-cycle low glitch on w_rxd while idle -> no byte strobe, no state change.
- With LOADER_CHECKSUM_EN: stream 01 00 AA BB CC DD plus checksum 01^AA^BB^CC^DD -> r_done=1. The same stream with checksum ^ 0x01 -> r_err=1, r_done=0, though the single word is still written.
